// File: rtl/regfile_sequencer_if.sv
// Request/control bundle between the requesters, the sequencer and the register file.
//   master: requester side, which drives req/op/sel/two and observes ack/err/busy/gnt and the controls.
//   slave : sequencer side, which receives the requests and drives every handshake and control output.
interface regfile_sequencer_if;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEL_W = 3;

    logic             req0, req1;
    logic [OP_W-1:0]  op0, op1;
    logic [SEL_W-1:0] sel0, sel1;
    logic             two0, two1;

    logic ack0, ack1, err, busy, gnt;
    logic bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw;
    logic rreg_rd, lreg_rd, rreg_wr, lreg_wr, dreg_rd, dreg_wr;
    logic dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2;

    modport master (
        output req0, req1, op0, op1, sel0, sel1, two0, two1,
        input  ack0, ack1, err, busy, gnt,
        input  bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw,
        input  rreg_rd, lreg_rd, rreg_wr, lreg_wr, dreg_rd, dreg_wr,
        input  dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2
    );

    modport slave (
        input  req0, req1, op0, op1, sel0, sel1, two0, two1,
        output ack0, ack1, err, busy, gnt,
        output bc_rw, de_rw, hl_rw, wz_rw, pc_rw, sp_rw,
        output rreg_rd, lreg_rd, rreg_wr, lreg_wr, dreg_rd, dreg_wr,
        output dreg_inc, dreg_dec, dreg_cnt, dreg_cnt2
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Round-robin arbiter plus strobe sequencer for the 16-bit register file.
// Grants req0 (fetch) or req1 (execute), then drives a one-hot pair select,
// a setup phase, one or two strobe pulses and a one-cycle ack.
// Ports:
//   phi1 : clock, all state changes on its rising edge
//   rst  : asynchronous reset, active-high
//   bus  : regfile_sequencer_if.slave (requests in; ack/err/busy/gnt, selects, strobes, inc/dec out)
// Parameters: SETUP_CYC (1..4) select-to-strobe cycles, STROBE_CYC (1..4) strobe width.
// Optional feature: define REGSEQ_OPCHECK_EN to reject op==NOP or sel>5 with an immediate ack+err.
module regfile_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic               phi1,
    input  logic               rst,
    regfile_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = 2;
    localparam logic [2:0] OP_NOP = 3'd0, OP_RDL = 3'd1, OP_RDH = 3'd2, OP_WRL = 3'd3;
    localparam logic [2:0] OP_WRH = 3'd4, OP_ADR = 3'd5, OP_INC = 3'd6, OP_DEC = 3'd7;
    // bit positions inside strb_q
    localparam int unsigned B_RREG_RD = 5, B_LREG_RD = 4, B_RREG_WR = 3;
    localparam int unsigned B_LREG_WR = 2, B_DREG_RD = 1, B_DREG_WR = 0;

    typedef enum logic [2:0] {IDLE, SETUP, STRB, MID, STRB2, HOLD} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d, sel_q, sel_d;
    logic             two_q, two_d, gnt_q, gnt_d, prio_q, prio_d, rej_q, rej_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;
    logic [5:0]       pair_q, pair_d;
    logic [5:0]       strb_q, strb_d;
    logic [3:0]       idc_q, idc_d;     // {inc, dec, cnt, cnt2}

    logic       pick;
    logic [2:0] pick_op, pick_sel;
    logic       bad, incdec, active;

    // Next state: arbitration, operand latch and phase counting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sel_d    = sel_q;
        two_d    = two_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        rej_d    = rej_q;
        pick     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
        pick_op  = pick ? bus.op1 : bus.op0;
        pick_sel = pick ? bus.sel1 : bus.sel0;
        incdec   = (op_q == OP_INC) || (op_q == OP_DEC);
`ifdef REGSEQ_OPCHECK_EN
        bad      = (pick_op == OP_NOP) || (pick_sel > 3'd5);
`else
        bad      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // The requester drops req on the edge after ack, so skip sampling while ack is out.
                if ((bus.req0 || bus.req1) && !(ack0_q || ack1_q)) begin
                    gnt_d   = pick;
                    prio_d  = ~pick;
                    op_d    = pick_op;
                    sel_d   = pick_sel;
                    two_d   = pick ? bus.two1 : bus.two0;
                    rej_d   = bad;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = bad ? HOLD : SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STRB;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STRB: begin
                if (cnt_q == '0) state_d = incdec ? MID : HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MID: begin
                state_d = STRB2;
                cnt_d   = CNT_W'(STROBE_CYC - 1);
            end
            STRB2: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the current state one cycle later, so select/inc/dec settle before strobes.
    always_comb begin
        active = (state_q != IDLE);
        busy_d = active;
        ack0_d = (state_q == HOLD) && !gnt_q;
        ack1_d = (state_q == HOLD) && gnt_q;
`ifdef REGSEQ_OPCHECK_EN
        err_d  = (state_q == HOLD) && rej_q;
`else
        err_d  = 1'b0;
`endif
        pair_d = '0;
        idc_d  = '0;
        strb_d = '0;
        if (active && !rej_q) begin
            pair_d = 6'b000001 << sel_q;   // sel 6/7 shifts out: no pair selected
            if (incdec) idc_d = {op_q == OP_INC, op_q == OP_DEC, !two_q, two_q};
        end
        if (state_q == STRB) begin
            unique case (op_q)
                OP_RDL:                 strb_d[B_RREG_RD] = 1'b1;
                OP_RDH:                 strb_d[B_LREG_RD] = 1'b1;
                OP_WRL:                 strb_d[B_RREG_WR] = 1'b1;
                OP_WRH:                 strb_d[B_LREG_WR] = 1'b1;
                OP_ADR, OP_INC, OP_DEC: strb_d[B_DREG_RD] = 1'b1;
                default: ;
            endcase
        end
        if (state_q == STRB2) strb_d[B_DREG_WR] = 1'b1;
    end

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sel_q   <= '0;
            two_q   <= 1'b0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            rej_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pair_q  <= '0;
            strb_q  <= '0;
            idc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            two_q   <= two_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            rej_q   <= rej_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            pair_q  <= pair_d;
            strb_q  <= strb_d;
            idc_q   <= idc_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.gnt       = gnt_q;
    assign bus.bc_rw     = pair_q[0];
    assign bus.de_rw     = pair_q[1];
    assign bus.hl_rw     = pair_q[2];
    assign bus.wz_rw     = pair_q[3];
    assign bus.pc_rw     = pair_q[4];
    assign bus.sp_rw     = pair_q[5];
    assign bus.rreg_rd   = strb_q[B_RREG_RD];
    assign bus.lreg_rd   = strb_q[B_LREG_RD];
    assign bus.rreg_wr   = strb_q[B_RREG_WR];
    assign bus.lreg_wr   = strb_q[B_LREG_WR];
    assign bus.dreg_rd   = strb_q[B_DREG_RD];
    assign bus.dreg_wr   = strb_q[B_DREG_WR];
    assign bus.dreg_inc  = idc_q[3];
    assign bus.dreg_dec  = idc_q[2];
    assign bus.dreg_cnt  = idc_q[1];
    assign bus.dreg_cnt2 = idc_q[0];
endmodule
